// File: rtl/char_ram_arbiter_if.sv
// Bus bundle between the arbiter, the text renderer, the host command port
// and the single-port character RAM.
interface char_ram_arbiter_if #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_DEPTH = 4
);
  localparam int unsigned LvlW = $clog2(CMD_DEPTH) + 1;

  // Renderer fetch path
  logic              render_req;
  logic [ADDR_W-1:0] render_addr;
  logic [DATA_W-1:0] render_data;
  logic              render_valid;

  // Host command / response path
  logic              host_cmd_valid;
  logic              host_cmd_ready;
  logic              host_cmd_we;
  logic [ADDR_W-1:0] host_cmd_addr;
  logic [DATA_W-1:0] host_cmd_wdata;
  logic              host_rsp_valid;
  logic [DATA_W-1:0] host_rsp_data;
  logic [LvlW-1:0]   cmd_level;

  // RAM macro port
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side
  modport slave (
    input  render_req, render_addr,
    output render_data, render_valid,
    input  host_cmd_valid, host_cmd_we, host_cmd_addr, host_cmd_wdata,
    output host_cmd_ready, host_rsp_valid, host_rsp_data, cmd_level,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  // Renderer / host / RAM side
  modport master (
    output render_req, render_addr,
    input  render_data, render_valid,
    output host_cmd_valid, host_cmd_we, host_cmd_addr, host_cmd_wdata,
    input  host_cmd_ready, host_rsp_valid, host_rsp_data, cmd_level,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/char_ram_arbiter.sv
// Character RAM arbiter: renderer fetches have absolute priority; host
// commands queue in an in-order FIFO and issue only in render-free cycles.
module char_ram_arbiter #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CMD_DEPTH = 4
) (
  input logic               pixel_clock,
  input logic               reset,
  char_ram_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned LvlW = $clog2(CMD_DEPTH) + 1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {GntIdle, GntRender, GntHost} grant_e;
  typedef enum logic [1:0] {TagNone, TagRender, TagHostRd} tag_e;

  cmd_t            cmd_mem_q [CMD_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;

  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

  // tag0 lines up with the registered RAM address, tag1 with ram_rdata
  tag_e tag0_q, tag0_d;
  tag_e tag1_q;

  logic              render_valid_q;
  logic [DATA_W-1:0] render_data_q;
  logic              host_rsp_valid_q;
  logic [DATA_W-1:0] host_rsp_data_q;

  grant_e grant;
  cmd_t   head;
  logic   ready;
  logic   push;
  logic   pop;

  assign head = cmd_mem_q[rd_ptr_q];

  // Grant decision, FIFO bookkeeping and next RAM port values
  always_comb begin
    grant       = GntIdle;
    ready       = (level_q < LvlW'(CMD_DEPTH));
    push        = bus.host_cmd_valid & ready;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    tag0_d      = TagNone;

    if (bus.render_req) begin
      grant = GntRender;
    end else if (level_q != '0) begin
      grant = GntHost;
    end
    pop = (grant == GntHost);

    unique case (grant)
      GntRender: begin
        ram_addr_d = bus.render_addr;
        tag0_d     = TagRender;
      end
      GntHost: begin
        ram_addr_d  = head.addr;
        ram_we_d    = head.we;
        ram_wdata_d = head.wdata;
        tag0_d      = head.we ? TagNone : TagHostRd;
      end
      default: ;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
  end

  // Command storage; pointers define validity so no reset is needed here
  always_ff @(posedge pixel_clock) begin
    if (push) begin
      cmd_mem_q[wr_ptr_q] <= {bus.host_cmd_we, bus.host_cmd_addr, bus.host_cmd_wdata};
    end
  end

  // FIFO pointers, registered RAM port and issue-tag pipeline
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag0_q      <= TagNone;
      tag1_q      <= TagNone;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag0_q;
    end
  end

  // Route returning read data to renderer or host according to its tag
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      render_valid_q   <= 1'b0;
      render_data_q    <= '0;
      host_rsp_valid_q <= 1'b0;
      host_rsp_data_q  <= '0;
    end else begin
      render_valid_q   <= (tag1_q == TagRender);
      host_rsp_valid_q <= (tag1_q == TagHostRd);
      if (tag1_q == TagRender) begin
        render_data_q <= bus.ram_rdata;
      end
      if (tag1_q == TagHostRd) begin
        host_rsp_data_q <= bus.ram_rdata;
      end
    end
  end

  assign bus.render_data    = render_data_q;
  assign bus.render_valid   = render_valid_q;
  assign bus.host_cmd_ready = ready;
  assign bus.host_rsp_valid = host_rsp_valid_q;
  assign bus.host_rsp_data  = host_rsp_data_q;
  assign bus.cmd_level      = level_q;
  assign bus.ram_addr       = ram_addr_q;
  assign bus.ram_we         = ram_we_q;
  assign bus.ram_wdata      = ram_wdata_q;

endmodule

// File: tb/tb_char_ram_arbiter.sv
// Directed self-checking bench for char_ram_arbiter with a behavioural
// single-port synchronous RAM attached to the RAM port.
module tb_char_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  char_ram_arbiter_if #(.ADDR_W(10), .DATA_W(8), .CMD_DEPTH(4)) bus ();

  char_ram_arbiter #(
    .ADDR_W   (10),
    .DATA_W   (8),
    .CMD_DEPTH(4)
  ) dut (
    .pixel_clock(clk),
    .reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // Background RAM contents before any write
  function automatic logic [7:0] prefill(input logic [9:0] a);
    return 8'(int'(a) * 5 + 7);
  endfunction

  // RAM model: read-old-data, one cycle read latency
  logic [7:0] mem [1024];
  bit         written [1024];
  always @(posedge clk) begin
    if (bus.ram_we) begin
      mem[bus.ram_addr]     <= bus.ram_wdata;
      written[bus.ram_addr] <= 1'b1;
    end
    bus.ram_rdata <= written[bus.ram_addr] ? mem[bus.ram_addr] : prefill(bus.ram_addr);
  end

  function automatic logic [7:0] ram_word(input logic [9:0] a);
    return written[a] ? mem[a] : prefill(a);
  endfunction

  logic [7:0] ref_mem [1024];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_drive(input logic v, input logic we, input logic [9:0] a,
                            input logic [7:0] d);
    bus.host_cmd_valid = v;
    bus.host_cmd_we    = we;
    bus.host_cmd_addr  = a;
    bus.host_cmd_wdata = d;
  endtask

  task automatic render_drive(input logic r, input logic [9:0] a);
    bus.render_req  = r;
    bus.render_addr = a;
  endtask

  typedef struct {
    bit       we;
    bit [9:0] addr;
    bit [7:0] wdata;
  } cmd_s;

  cmd_s        cmds [12];
  logic [17:0] exp_wr [$];
  logic [7:0]  exp_rd [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc;
    int pulses;
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) ref_mem[i] = prefill(10'(i));
    render_drive(1'b0, '0);
    host_drive(1'b0, 1'b0, '0, '0);

    // ---- Reset then idle
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq("idle_ready", bus.host_cmd_ready, 1);
      check_eq("idle_level", bus.cmd_level, 0);
      check_eq("idle_we", bus.ram_we, 0);
      check_eq("idle_rvalid", bus.render_valid, 0);
      check_eq("idle_hvalid", bus.host_rsp_valid, 0);
    end
    check_eq("rst_rdata", bus.render_data, 0);
    check_eq("rst_hdata", bus.host_rsp_data, 0);
    check_eq("rst_raddr", bus.ram_addr, 0);
    check_eq("rst_wdata", bus.ram_wdata, 0);

    // ---- Single host write, then render fetch of the same cell
    tick();
    host_drive(1'b1, 1'b1, 10'h005, 8'h41);
    check_eq("w1_ready", bus.host_cmd_ready, 1);
    tick();
    host_drive(1'b0, 1'b0, '0, '0);
    check_eq("w1_level", bus.cmd_level, 1);
    check_eq("w1_we_early", bus.ram_we, 0);
    tick();
    check_eq("w1_we", bus.ram_we, 1);
    check_eq("w1_addr", bus.ram_addr, 10'h005);
    check_eq("w1_wdata", bus.ram_wdata, 8'h41);
    ref_mem[10'h005] = 8'h41;
    tick();
    check_eq("w1_we_off", bus.ram_we, 0);
    render_drive(1'b1, 10'h005);
    tick();
    render_drive(1'b0, '0);
    tick();
    check_eq("r1_early", bus.render_valid, 0);
    tick();
    check_eq("r1_valid", bus.render_valid, 1);
    check_eq("r1_data", bus.render_data, 8'h41);
    tick();
    check_eq("r1_valid_off", bus.render_valid, 0);
    check_eq("r1_data_hold", bus.render_data, 8'h41);

    // ---- Continuous rendering starves the host; FIFO fills to 4
    repeat (3) tick();
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      render_drive(1'b1, 10'h100 + 10'(c));
      if (acc < 6) host_drive(1'b1, 1'b1, 10'h020 + 10'(acc), 8'hC0 + 8'(acc));
      else host_drive(1'b0, 1'b0, '0, '0);
      check_eq("starve_we", bus.ram_we, 0);
      check_eq("starve_level_max", bus.cmd_level <= 4, 1);
      if (c >= 3) begin
        check_eq("stream_valid", bus.render_valid, 1);
        check_eq("stream_data", bus.render_data, ref_mem[10'h100 + 10'(c - 3)]);
      end else begin
        check_eq("stream_fill", bus.render_valid, 0);
      end
      if (bus.host_cmd_valid && bus.host_cmd_ready) acc++;
    end
    tick();
    render_drive(1'b0, '0);
    host_drive(1'b0, 1'b0, '0, '0);
    check_eq("starve_accepted", acc, 4);
    check_eq("starve_ready", bus.host_cmd_ready, 0);
    check_eq("starve_level", bus.cmd_level, 4);
    for (int j = 0; j < 4; j++) begin
      tick();
      check_eq("drain_we", bus.ram_we, 1);
      check_eq("drain_addr", bus.ram_addr, 10'h020 + 10'(j));
      check_eq("drain_wdata", bus.ram_wdata, 8'hC0 + 8'(j));
      check_eq("drain_level", bus.cmd_level, 3 - j);
      check_eq("drain_ready", bus.host_cmd_ready, 1);
      ref_mem[10'h020 + 10'(j)] = 8'hC0 + 8'(j);
    end
    tick();
    check_eq("drain_we_off", bus.ram_we, 0);
    check_eq("drain_level0", bus.cmd_level, 0);

    // ---- Write/read 0x3FF back-to-back, renders on alternate cycles
    repeat (4) tick();
    pulses = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k < 8 && (k % 2) == 0) render_drive(1'b1, 10'h200 + 10'(k));
      else render_drive(1'b0, '0);
      if (k == 0) host_drive(1'b1, 1'b1, 10'h3FF, 8'hB0);
      else if (k == 1) host_drive(1'b1, 1'b0, 10'h3FF, 8'h00);
      else host_drive(1'b0, 1'b0, '0, '0);
      if (k < 2) check_eq("wr_rd_ready", bus.host_cmd_ready, 1);
      if (k >= 3 && k <= 9 && (k % 2) == 1) begin
        check_eq("ilv_rvalid", bus.render_valid, 1);
        check_eq("ilv_rdata", bus.render_data, ref_mem[10'h200 + 10'(k - 3)]);
      end else begin
        check_eq("ilv_rvalid_off", bus.render_valid, 0);
      end
      check_eq("ilv_hvalid", bus.host_rsp_valid, k == 6);
      if (k == 6) check_eq("ilv_hdata", bus.host_rsp_data, 8'hB0);
      check_eq("ilv_excl", bus.render_valid & bus.host_rsp_valid, 0);
      if (bus.host_rsp_valid) pulses++;
    end
    ref_mem[10'h3FF] = 8'hB0;
    check_eq("ilv_pulses", pulses, 1);

    // ---- Twelve mixed commands with valid held high, checked against a model
    for (int i = 0; i < 12; i++) begin
      a = 10'h040 + 10'(i / 3);
      cmds[i].addr  = a;
      cmds[i].wdata = 8'h00;
      cmds[i].we    = 1'b0;
      case (i % 3)
        0: begin
          cmds[i].we    = 1'b1;
          cmds[i].wdata = 8'hA0 + 8'(i);
          ref_mem[a]    = 8'hA0 + 8'(i);
          exp_wr.push_back({a, 8'hA0 + 8'(i)});
        end
        1: exp_rd.push_back(ref_mem[a]);
        default: begin
          cmds[i].addr = a + 10'h010;
          exp_rd.push_back(ref_mem[a + 10'h010]);
        end
      endcase
    end
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      render_drive(1'b0, '0);
      if (acc < 12) host_drive(1'b1, cmds[acc].we, cmds[acc].addr, cmds[acc].wdata);
      else host_drive(1'b0, 1'b0, '0, '0);
      check_eq("wrap_level_max", bus.cmd_level <= 4, 1);
      if (bus.ram_we) begin
        if (exp_wr.size() == 0) check_eq("wrap_extra_write", 1, 0);
        else check_eq("wrap_write", {bus.ram_addr, bus.ram_wdata}, exp_wr.pop_front());
      end
      if (bus.host_rsp_valid) begin
        if (exp_rd.size() == 0) check_eq("wrap_extra_rsp", 1, 0);
        else check_eq("wrap_rsp", bus.host_rsp_data, exp_rd.pop_front());
      end
      if (bus.host_cmd_valid && bus.host_cmd_ready) acc++;
    end
    check_eq("wrap_accepted", acc, 12);
    check_eq("wrap_wr_left", exp_wr.size(), 0);
    check_eq("wrap_rd_left", exp_rd.size(), 0);
    check_eq("wrap_level_end", bus.cmd_level, 0);

    // ---- Reset with three commands queued and a host read in flight
    repeat (3) tick();
    tick();
    render_drive(1'b1, 10'h300);
    host_drive(1'b1, 1'b0, 10'h050, 8'h00);
    tick();
    host_drive(1'b1, 1'b1, 10'h060, 8'hEE);
    tick();
    render_drive(1'b0, '0);
    host_drive(1'b1, 1'b1, 10'h061, 8'hEE);
    tick();
    render_drive(1'b1, 10'h301);
    host_drive(1'b1, 1'b1, 10'h062, 8'hEE);
    tick();
    render_drive(1'b0, '0);
    host_drive(1'b0, 1'b0, '0, '0);
    check_eq("mid_level", bus.cmd_level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("mid_level_clr", bus.cmd_level, 0);
    check_eq("mid_ready", bus.host_cmd_ready, 1);
    for (int c = 0; c < 10; c++) begin
      check_eq("mid_hvalid", bus.host_rsp_valid, 0);
      check_eq("mid_rvalid", bus.render_valid, 0);
      check_eq("mid_we", bus.ram_we, 0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      check_eq("mid_mem_intact", ram_word(10'h060 + 10'(j)), ref_mem[10'h060 + 10'(j)]);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/char_ram_arbiter.md
Name: char_ram_arbiter

Overview:
- Shares the single-port synchronous character RAM between the text renderer's glyph-code fetch path and a host command port (writes and readback).
- Renderer fetches always win, because display timing cannot stall.
- Host commands are buffered in an in-order command FIFO and issued only in cycles with no render fetch.
- Sits between render_mod (char_index/char_data) and the character RAM macro.

Parameters:
- ADDR_W, 10, character-cell address width (matches char_index)
- DATA_W, 8, character code width
- CMD_DEPTH, 4, host command FIFO depth; power of 2, ≥2

Ports:
- pixel_clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high; clears all state
- render_req  in  1  renderer fetch request this cycle
- render_addr  in  ADDR_W  cell address (renderer char_index)
- render_data  out  DATA_W  fetched character code (renderer char_data)
- render_valid  out  1  render_data updated this cycle
- host_cmd_valid  in  1  host command offered
- host_cmd_ready  out  1  FIFO can accept a command
- host_cmd_we  in  1  1 = write, 0 = read
- host_cmd_addr  in  ADDR_W  command address
- host_cmd_wdata  in  DATA_W  write data (ignored for reads)
- host_rsp_valid  out  1  one-cycle pulse: read response
- host_rsp_data  out  DATA_W  read data
- cmd_level  out  $clog2(CMD_DEPTH)+1  FIFO occupancy
- ram_addr  out  ADDR_W  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after address

Behaviour:
- Reset values:
  - render_data, host_rsp_data, ram_addr, ram_wdata, cmd_level: 0
  - render_valid, host_rsp_valid, ram_we: 0
  - host_cmd_ready: 1
  - FIFO empty, in-flight tags cleared.
- Grant, decided combinationally each cycle:
  - render_req=1 → RENDER: ram_addr=render_addr, ram_we=0.
  - Else if FIFO non-empty → HOST: pop head; ram_addr=head.addr, ram_we=head.we, ram_wdata=head.wdata.
  - Else IDLE: ram_we=0, ram_addr holds its previous value.
- RAM port outputs are registered copies of the grant decision, so RAM sees the access 1 cycle after grant.
- Issue tag pipeline: a 2-stage shift of {kind ∈ none/render/hostread}, aligned to ram_rdata.
  - The cycle ram_rdata is valid for a render read: render_data<=ram_rdata, render_valid=1.
  - For a host read: host_rsp_data<=ram_rdata, host_rsp_valid=1.
  - Host writes produce no response.
- Latency: render_req at cycle N → render_valid/render_data at N+3, fixed. Back-to-back render_req every cycle is sustained at 1/cycle.
- render_data holds its last value when render_valid=0.
- host_rsp_valid and render_valid never assert in the same cycle.
- FIFO:
  - Enqueue when host_cmd_valid & host_cmd_ready.
  - host_cmd_ready = (cmd_level < CMD_DEPTH), registered-state based; a same-cycle pop does not raise ready.
  - Enqueue and pop in the same cycle: level unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- Ordering:
  - Host commands execute strictly in enqueue order.
  - A read after a write to the same address returns the new data (the RAM write precedes the read issue).
  - Render reads are not ordered against host writes: a same-address render fetch in the write's cycle or earlier sees old data.
- Starvation: host commands wait indefinitely while render_req=1 every cycle. No timeout, no drop.
- Reset mid-operation:
  - FIFO is flushed; in-flight render/host reads are discarded with no valid pulse.
  - A RAM write already registered to the port completes (ram_we was asserted); ram_we=0 from the following cycle.

Test Plan:
- Reset then idle → host_cmd_ready=1, cmd_level=0, ram_we=0, render_valid=0, host_rsp_valid=0 for 20 cycles.
- Host write addr 0x005 data 0x41, render_req low → ram_we=1 with ram_addr=0x005, ram_wdata=0x41 two cycles after accept. Then render_req addr 0x005 → render_data=0x41, render_valid 3 cycles later.
- Continuous render_req for 30 cycles while host offers 6 writes:
  - exactly 4 are accepted, then host_cmd_ready=0 and cmd_level=4;
  - ram_we stays 0 throughout;
  - after render_req drops, the 4 writes issue on consecutive cycles in order;
  - ready reasserts after the first pop is registered.
- Host write 0x3FF=0xB0 then read 0x3FF, back-to-back → host_rsp_valid single pulse, data 0xB0. Render interleaved on alternate cycles still gets render_valid at N+3 for each request.
- FIFO wrap: 12 mixed commands with host_cmd_valid held high and render idle → all 12 complete in order; read responses match a reference model; cmd_level never exceeds 4.
- Assert reset with 3 queued commands and a host read in flight → no host_rsp_valid pulse, cmd_level=0 next cycle, queued writes never reach the RAM.
